// File: rtl/uart_receiver.sv
// 8-bit UART receiver: 2-FF input synchronizer, oversampled mid-bit sampling, framing check.
// Define UART_RX_PARITY_EN to expect one even-parity bit after D7 (default build: 8N1, parity_err tied low).
module uart_receiver #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int OVS      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rxd,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam int DIV = CLK_FREQ / (BAUD * OVS);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVS) + 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  // START samples on the (OVS/2-1)th tick, later bits on every OVS-th tick.
  localparam logic [TW-1:0] START_LAST = TW'(OVS / 2 - 2);
  localparam logic [TW-1:0] BIT_LAST   = TW'(OVS - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY    = 3'd3;
`endif
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

  logic [1:0]    sync_reg;
  logic          rxs;
  logic [DW-1:0] div_cnt_reg;
  logic          tick;
  logic          sample;
  logic          parity_ok;

  logic [2:0]    state_reg,    state_next;
  logic [TW-1:0] tick_cnt_reg, tick_cnt_next;
  logic [2:0]    bit_idx_reg,  bit_idx_next;
  logic [7:0]    shift_reg,    shift_next;
  logic [7:0]    rx_data_reg,  rx_data_next;
  logic          rx_done_reg,  rx_done_next;
  logic          frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_EN
  logic          parity_bad_reg, parity_bad_next;
  logic          parity_err_reg, parity_err_next;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], i_rxd};
    end
  end
  assign rxs = sync_reg[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_reg <= '0;
    end else if (div_cnt_reg == DIV_LAST) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end
  assign tick = (div_cnt_reg == DIV_LAST);

  assign sample = tick && (tick_cnt_reg == ((state_reg == ST_START) ? START_LAST : BIT_LAST));

`ifdef UART_RX_PARITY_EN
  assign parity_ok = !parity_bad_reg;
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_next     = state_reg;
    tick_cnt_next  = tick_cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    rx_data_next   = rx_data_reg;
    rx_done_next   = 1'b0;
    frame_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_next = parity_bad_reg;
    parity_err_next = 1'b0;
`endif
    if (tick && state_reg != ST_IDLE && state_reg != ST_WAIT_HIGH) begin
      tick_cnt_next = sample ? '0 : tick_cnt_reg + 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (!rxs) begin
          state_next    = ST_START;
          tick_cnt_next = '0;
        end
      end
      ST_START: begin
        if (sample) begin
          if (!rxs) begin
            state_next   = ST_DATA;
            bit_idx_next = 3'd0;
`ifdef UART_RX_PARITY_EN
            parity_bad_next = 1'b0;
`endif
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (sample) begin
          shift_next   = {rxs, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 1'b1;
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (sample) begin
          parity_bad_next = ((^shift_reg) != rxs);
          parity_err_next = ((^shift_reg) != rxs);
          state_next      = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (sample) begin
          if (rxs) begin
            state_next = ST_IDLE;
            if (parity_ok) begin
              rx_data_next = shift_reg;
              rx_done_next = 1'b1;
            end
          end else begin
            frame_err_next = 1'b1;
            state_next     = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        // A held-low line (break) must go high before another start edge counts.
        if (rxs) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      tick_cnt_reg  <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      rx_data_reg   <= '0;
      rx_done_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tick_cnt_reg  <= tick_cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      rx_data_reg   <= rx_data_next;
      rx_done_reg   <= rx_done_next;
      frame_err_reg <= frame_err_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_bad_reg <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      parity_bad_reg <= parity_bad_next;
      parity_err_reg <= parity_err_next;
    end
  end
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = rx_data_reg;
  assign rx_done   = rx_done_reg;
  assign frame_err = frame_err_reg;
  assign rx_busy   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver, scaled to 64 clk per bit (DIV=4, OVS=16).
// Follows the DUT build: frames carry an even-parity bit when UART_RX_PARITY_EN is defined.
module tb_uart_receiver;

  localparam int CLK_FREQ = 6_400_000;
  localparam int BAUD     = 100_000;
  localparam int OVS      = 16;
  localparam int BIT_CLKS = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       i_rxd;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  int vectors = 0;
  int miscompares = 0;

  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         busy_cnt = 0;
  int         silent_changes = 0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] last_done_data = 8'h00;
  logic [7:0] prev_done_data = 8'h00;

  uart_receiver #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .OVS     (OVS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_rxd     (i_rxd),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  // Pulse counters count high cycles, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (reset) begin
      if (rx_done) begin
        done_cnt       <= done_cnt + 1;
        prev_done_data <= last_done_data;
        last_done_data <= rx_data;
      end
      if (frame_err)  ferr_cnt <= ferr_cnt + 1;
      if (parity_err) perr_cnt <= perr_cnt + 1;
      if (rx_busy)    busy_cnt <= busy_cnt + 1;
      if (rx_data != prev_data && !rx_done) silent_changes <= silent_changes + 1;
    end
    prev_data <= rx_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    i_rxd = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par === 1'bx) $display("note: parity argument unused in 8N1 build");
`endif
    drive_bit(stop);
    i_rxd = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    i_rxd = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  initial begin
    int d0, f0, b0;

    reset = 1'b0;
    i_rxd = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_rx_data",    32'(rx_data),    32'h00);
    check("reset_rx_done",    32'(rx_done),    32'h0);
    check("reset_frame_err",  32'(frame_err),  32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    check("reset_rx_busy",    32'(rx_busy),    32'h0);
    reset = 1'b1;
    idle_bits(2);

    // 0x55, good frame
    d0 = done_cnt; f0 = ferr_cnt; b0 = busy_cnt;
    send_frame(8'h55, ^8'h55, 1'b1);
    idle_bits(1);
    check("t55_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t55_rx_data",     32'(rx_data),       32'h55);
    check("t55_no_frame_err", 32'(ferr_cnt - f0), 32'd0);
    check("t55_busy_len_ok",
          32'((busy_cnt - b0 >= (FRAME_BITS - 1) * BIT_CLKS) && (busy_cnt - b0 <= FRAME_BITS * BIT_CLKS)),
          32'd1);
    $display("frame 0x55: done=%0d data=%0h busy_clks=%0d", done_cnt - d0, rx_data, busy_cnt - b0);

    // short low glitch, well under half a bit
    d0 = done_cnt; f0 = ferr_cnt;
    i_rxd = 1'b0;
    repeat (12) @(negedge clk);
    idle_bits(2);
    check("glitch_no_done",  32'(done_cnt - d0), 32'd0);
    check("glitch_no_ferr",  32'(ferr_cnt - f0), 32'd0);
    check("glitch_idle",     32'(rx_busy),       32'd0);
    check("glitch_keep_data", 32'(rx_data),      32'h55);
    $display("glitch 12 clk: done=%0d ferr=%0d busy=%0d", done_cnt - d0, ferr_cnt - f0, rx_busy);

    // break: line low for 15 bit times
    d0 = done_cnt; f0 = ferr_cnt;
    i_rxd = 1'b0;
    repeat (15 * BIT_CLKS) @(negedge clk);
    check("break_busy_while_low", 32'(rx_busy), 32'd1);
    idle_bits(2);
    check("break_one_ferr", 32'(ferr_cnt - f0), 32'd1);
    check("break_no_done",  32'(done_cnt - d0), 32'd0);
    check("break_idle",     32'(rx_busy),       32'd0);
    $display("break: ferr=%0d done=%0d busy=%0d", ferr_cnt - f0, done_cnt - d0, rx_busy);

    // 0xA3 with bad stop, then 0x0F
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'hA3, ^8'hA3, 1'b0);
    idle_bits(1);
    check("tA3_ferr",      32'(ferr_cnt - f0), 32'd1);
    check("tA3_no_done",   32'(done_cnt - d0), 32'd0);
    check("tA3_keep_data", 32'(rx_data),       32'h55);
    $display("frame 0xA3 bad stop: ferr=%0d data=%0h", ferr_cnt - f0, rx_data);
    d0 = done_cnt;
    send_frame(8'h0F, ^8'h0F, 1'b1);
    idle_bits(1);
    check("t0F_done",    32'(done_cnt - d0), 32'd1);
    check("t0F_rx_data", 32'(rx_data),       32'h0F);
    $display("frame 0x0F: done=%0d data=%0h", done_cnt - d0, rx_data);

    // 0x00 then 0xFF with no idle gap
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h00, ^8'h00, 1'b1);
    send_frame(8'hFF, ^8'hFF, 1'b1);
    idle_bits(1);
    check("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);
    check("b2b_first",       32'(prev_done_data), 32'h00);
    check("b2b_second",      32'(last_done_data), 32'hFF);
    check("b2b_no_ferr",     32'(ferr_cnt - f0),  32'd0);
    $display("frames 0x00,0xFF: done=%0d first=%0h second=%0h", done_cnt - d0, prev_done_data, last_done_data);

    // reset in the middle of bit 4 of 0x3C, then 0x81
    d0 = done_cnt; f0 = ferr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[1]);
    i_rxd = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("midreset_rx_data", 32'(rx_data), 32'h00);
    check("midreset_busy",    32'(rx_busy), 32'd0);
    reset = 1'b1;
    idle_bits(2);
    check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
    send_frame(8'h81, ^8'h81, 1'b1);
    idle_bits(1);
    check("t81_done",    32'(done_cnt - d0), 32'd1);
    check("t81_rx_data", 32'(rx_data),       32'h81);
    check("t81_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    $display("abort 0x3C then 0x81: done=%0d data=%0h", done_cnt - d0, rx_data);

`ifdef UART_RX_PARITY_EN
    d0 = done_cnt; f0 = perr_cnt;
    send_frame(8'h07, 1'b0, 1'b1);
    idle_bits(1);
    check("par_bad_perr",    32'(perr_cnt - f0), 32'd1);
    check("par_bad_no_done", 32'(done_cnt - d0), 32'd0);
    check("par_bad_keep",    32'(rx_data),       32'h81);
    $display("frame 0x07 parity 0: perr=%0d done=%0d data=%0h", perr_cnt - f0, done_cnt - d0, rx_data);
    d0 = done_cnt; f0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(1);
    check("par_good_done",    32'(done_cnt - d0), 32'd1);
    check("par_good_no_perr", 32'(perr_cnt - f0), 32'd0);
    check("par_good_data",    32'(rx_data),       32'h07);
    $display("frame 0x07 parity 1: perr=%0d done=%0d data=%0h", perr_cnt - f0, done_cnt - d0, rx_data);
`else
    check("no_parity_err_8n1", 32'(perr_cnt), 32'd0);
`endif

    check("data_changed_without_done", 32'(silent_changes), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line bit rate.
REQ-003 SHALL have parameter OVS, default 16, oversample ticks per bit.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset; the block is in reset while reset==0.
REQ-006 SHALL have port i_rxd  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rx_data  output  8  last correctly received byte.
REQ-008 SHALL have port rx_done  output  1  one-clk pulse when rx_data is updated.
REQ-009 SHALL have port frame_err  output  1  one-clk pulse when the stop bit is sampled low.
REQ-010 SHALL have port parity_err  output  1  one-clk pulse on parity mismatch (see Configuration).
REQ-011 SHALL have port rx_busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL pass i_rxd through a 2-FF synchronizer; all decisions use the synchronized value (rxs).
REQ-013 SHALL generate an internal oversample tick: counter 0..DIV-1, DIV=CLK_FREQ/(BAUD*OVS) (651 at defaults), tick one clk wide at count DIV-1, free-running.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-015 IDLE: on rxs==0, go to START and clear the tick-in-bit counter.
REQ-016 START: after OVS/2-1 ticks (7), sample rxs; 0 -> DATA with bit index 0; 1 -> IDLE (glitch rejected, no outputs).
REQ-017 DATA: sample every OVS ticks (mid-bit); shift in LSB first; after the 8th sample go to PARITY if compiled in, else STOP.
REQ-018 STOP: sample after OVS ticks; 1 -> load rx_data, pulse rx_done, go to IDLE; 0 -> pulse frame_err, keep rx_data unchanged, go to WAIT_HIGH.
REQ-019 WAIT_HIGH: stay until rxs==1, then IDLE (a break does not trigger a new frame).
REQ-020 rx_done/frame_err/parity_err SHALL assert in the clk after the deciding sample tick and last exactly one clk.
REQ-021 rx_data SHALL hold its value until the next successful frame; SHALL never change without rx_done.
REQ-022 SHALL accept back-to-back frames: a start edge in the clk after returning to IDLE begins a new frame.

Reset
REQ-023 While reset==0: state=IDLE, rx_data=8'h00, rx_done=0, frame_err=0, parity_err=0, rx_busy=0, synchronizer FFs=1, all counters=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, reception resumes on the next falling edge.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: one even-parity bit follows D7; PARITY state samples it after OVS ticks; mismatch -> pulse parity_err, keep rx_data, no rx_done, still proceed to STOP and WAIT_HIGH/IDLE per stop bit (frame_err may also pulse).
REQ-026 Macro undefined: no PARITY state, 10-bit frame, parity_err tied 0.

Verification (defaults: 1 bit = 10416 clk)
REQ-027 Send 0x55, 8N1 -> rx_data=0x55, single rx_done pulse, rx_busy high for about 9.5 bit times.
REQ-028 Hold i_rxd low 2000 clk, then high -> no rx_done/frame_err, state returns to IDLE.
REQ-029 Send 0xA3 with stop bit low, line then high; then send 0x0F -> frame_err pulse, rx_data keeps its old value, then 0x0F with rx_done.
REQ-030 Send 0x00 then 0xFF back-to-back with no idle gap -> two rx_done pulses, values 0x00 then 0xFF.
REQ-031 Assert reset at bit 4 of 0x3C, release, send 0x81 -> no output for 0x3C, rx_data=0x81.
REQ-032 With UART_RX_PARITY_EN: send 0x07 with parity bit 0 -> parity_err pulse, no rx_done; send 0x07 with parity 1 -> rx_done, rx_data=0x07.
